// File: rtl/mp3_btn_pkg.sv
// Shared constants and helpers for the MP3 button conditioner.
// Cycle defaults assume a 50 MHz system clock.
package mp3_btn_pkg;

  localparam int unsigned DEBOUNCE_50M = 1000000;
  localparam int unsigned LONG_50M     = 50000000;
  localparam int unsigned REPEAT_50M   = 10000000;

  // clog2(n) with a floor of 1 bit
  function automatic int unsigned cnt_width(input int unsigned n);
    int unsigned w;
    w = 1;
    for (int i = 1; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/mp3_btn_channel.sv
// One button channel: 2-flop sync, debounce, hold timer, optional repeat.
// Auto-repeat is built when MP3_BTN_AUTO_REPEAT_EN is defined.
module mp3_btn_channel
  import mp3_btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_50M,
  parameter int unsigned LONG_CYCLES     = LONG_50M,
  parameter int unsigned REPEAT_CYCLES   = REPEAT_50M
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic key_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic long_o
);

  localparam int unsigned DW = cnt_width(DEBOUNCE_CYCLES);
  localparam int unsigned HW = cnt_width(LONG_CYCLES) + 1;
  localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] H_LAST = HW'(LONG_CYCLES - 1);
  localparam logic [HW-1:0] H_SAT  = HW'(LONG_CYCLES);

  if (DEBOUNCE_CYCLES < 2) begin : g_bad_db
    $error("DEBOUNCE_CYCLES must be >= 2");
  end
  if (LONG_CYCLES <= DEBOUNCE_CYCLES) begin : g_bad_long
    $error("LONG_CYCLES must exceed DEBOUNCE_CYCLES");
  end
  if (REPEAT_CYCLES < 1) begin : g_bad_rep
    $error("REPEAT_CYCLES must be >= 1");
  end

  logic [1:0]    sync_q, sync_d;
  logic          stable_q, stable_d;
  logic [DW-1:0] dc_q, dc_d;
  logic [HW-1:0] hc_q, hc_d;
  logic          press_q, press_d;
  logic          rel_q, rel_d;
  logic          long_q, long_d;
  logic          s;

  assign s = sync_q[1];

`ifdef MP3_BTN_AUTO_REPEAT_EN
  localparam int unsigned RW = cnt_width(REPEAT_CYCLES);
  localparam logic [RW-1:0] R_LAST = RW'(REPEAT_CYCLES - 1);

  logic [RW-1:0] rc_q, rc_d;
  logic          rep;

  always_comb begin
    rc_d = '0;
    rep  = 1'b0;
    if (stable_q && hc_q == H_SAT && !rel_d) begin
      if (rc_q == R_LAST) rep = 1'b1;
      else rc_d = rc_q + RW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) rc_q <= '0;
    else rc_q <= rc_d;
  end
`else
  logic rep;
  assign rep = 1'b0;
`endif

  always_comb begin
    sync_d   = {sync_q[0], key_i};
    stable_d = stable_q;
    dc_d     = '0;
    press_d  = 1'b0;
    rel_d    = 1'b0;
    if (s != stable_q) begin
      if (dc_q == D_LAST) begin
        stable_d = s;
        press_d  = s;
        rel_d    = ~s;
      end else begin
        dc_d = dc_q + DW'(1);
      end
    end
    press_d = press_d | rep;
  end

  // hc saturates at LONG_CYCLES so long_o fires once per hold
  always_comb begin
    hc_d   = '0;
    long_d = 1'b0;
    if (stable_q) begin
      hc_d   = (hc_q == H_SAT) ? hc_q : hc_q + HW'(1);
      long_d = (hc_q == H_LAST);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q   <= '0;
      stable_q <= 1'b0;
      dc_q     <= '0;
      hc_q     <= '0;
      press_q  <= 1'b0;
      rel_q    <= 1'b0;
      long_q   <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      stable_q <= stable_d;
      dc_q     <= dc_d;
      hc_q     <= hc_d;
      press_q  <= press_d;
      rel_q    <= rel_d;
      long_q   <= long_d;
    end
  end

  assign level_o   = stable_q;
  assign press_o   = press_q;
  assign release_o = rel_q;
  assign long_o    = long_q;

endmodule

// File: rtl/mp3_button_conditioner.sv
// Conditions raw board keys into clean levels and event pulses.
// Optional auto-repeat: define MP3_BTN_AUTO_REPEAT_EN.
module mp3_button_conditioner
  import mp3_btn_pkg::*;
#(
  parameter int unsigned N_BTN           = 3,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_50M,
  parameter int unsigned LONG_CYCLES     = LONG_50M,
  parameter int unsigned REPEAT_CYCLES   = REPEAT_50M,
  parameter int unsigned ACTIVE_LOW      = 1
) (
  input  logic             clk_clk,
  input  logic             reset_reset,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] buttons_export_export,
  output logic [N_BTN-1:0] press_pulse,
  output logic [N_BTN-1:0] release_pulse,
  output logic [N_BTN-1:0] long_pulse
);

  localparam logic POL = (ACTIVE_LOW != 0);

  logic [N_BTN-1:0] key;

  // after this, 1 always means pressed
  assign key = btn_raw ^ {N_BTN{POL}};

  for (genvar g = 0; g < N_BTN; g++) begin : g_ch
    mp3_btn_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .LONG_CYCLES    (LONG_CYCLES),
      .REPEAT_CYCLES  (REPEAT_CYCLES)
    ) u_ch (
      .clk_i    (clk_clk),
      .rst_i    (reset_reset),
      .key_i    (key[g]),
      .level_o  (buttons_export_export[g]),
      .press_o  (press_pulse[g]),
      .release_o(release_pulse[g]),
      .long_o   (long_pulse[g])
    );
  end

endmodule

// File: tb/tb_mp3_button_conditioner.sv
// Directed bench for mp3_button_conditioner (D=4, L=20, R=8).
// Inputs change and outputs are sampled on the falling edge.
module tb_mp3_button_conditioner;

  localparam int D = 4;
  localparam int L = 20;
  localparam int R = 8;

`ifdef MP3_BTN_AUTO_REPEAT_EN
  localparam bit REP_ON = 1'b1;
`else
  localparam bit REP_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] raw;
  logic [2:0] lvl, prs, rel, lng;

  int checks   = 0;
  int failures = 0;

  mp3_button_conditioner #(
    .N_BTN          (3),
    .DEBOUNCE_CYCLES(D),
    .LONG_CYCLES    (L),
    .REPEAT_CYCLES  (R),
    .ACTIVE_LOW     (1)
  ) dut (
    .clk_clk              (clk),
    .reset_reset          (rst),
    .btn_raw              (raw),
    .buttons_export_export(lvl),
    .press_pulse          (prs),
    .release_pulse        (rel),
    .long_pulse           (lng)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] vec(input int ch);
    return {lvl[ch], prs[ch], rel[ch], lng[ch]};
  endfunction

  // Step n cycles, checking {level,press,release,long} of one channel.
  task automatic watch(input string tag, input int ch, input int n,
                       input logic lvl0, input int p_at,
                       input int r_at, input int l_at);
    logic [3:0] e;
    logic       el;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      el = lvl0;
      if (p_at != 0 && k >= p_at) el = 1'b1;
      if (r_at != 0 && k >= r_at) el = 1'b0;
      e = {el, 1'(k == p_at), 1'(k == r_at), 1'(k == l_at)};
      chk($sformatf("%s k=%0d", tag, k), 32'(vec(ch)), 32'(e));
    end
  endtask

  initial begin
    rst = 1'b1;
    raw = 3'b111;
    repeat (3) @(negedge clk);
    chk("reset_out", {20'd0, lvl, prs, rel, lng}, 32'd0);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("idle", {20'd0, lvl, prs, rel, lng}, 32'd0);
    end

    // clean press then release on channel 0
    raw[0] = 1'b0;
    watch("p0", 0, 8, 1'b0, 6, 0, 0);
    raw[0] = 1'b1;
    watch("r0", 0, 8, 1'b1, 0, 6, 0);

    // bounce on channel 1: 3 low, 1 high, then low held
    raw[1] = 1'b0;
    watch("b1_lo", 1, 3, 1'b0, 0, 0, 0);
    raw[1] = 1'b1;
    watch("b1_hi", 1, 1, 1'b0, 0, 0, 0);
    raw[1] = 1'b0;
    watch("b1_on", 1, 8, 1'b0, 6, 0, 0);

    // long hold on channel 2: long at press+20, release 6 later
    raw[2] = 1'b0;
    watch("h2", 2, 36, 1'b0, 6, 0, 26);
    raw[2] = 1'b1;
    watch("h2_rel", 2, 8, 1'b1, 0, 6, 0);

    // short press on channel 2: no long pulse
    raw[2] = 1'b0;
    watch("s2", 2, 10, 1'b0, 6, 0, 0);
    raw[2] = 1'b1;
    watch("s2_rel", 2, 20, 1'b1, 0, 6, 0);

    // long hold on channel 0 with repeat window
    raw[0] = 1'b0;
    for (int k = 1; k <= 6 + L + 41; k++) begin
      logic ep;
      @(negedge clk);
      ep = (k == 6) ||
           (REP_ON && k > 6 + L && ((k - 6 - L) % R) == 0);
      chk($sformatf("rep0 k=%0d", k), 32'(vec(0)),
          32'({1'(k >= 6), ep, 1'b0, 1'(k == 6 + L)}));
    end

    // reset mid-hold; press re-reported after reset
    rst = 1'b1;
    @(negedge clk);
    chk("mid_reset", {20'd0, lvl, prs, rel, lng}, 32'd0);
    rst = 1'b0;
    watch("re0", 0, 8, 1'b0, 6, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
